seq_divider: RTL

Sequential restoring divider: the inverse companion of the team's Booth multiplier datapath. It accepts an N-bit dividend and divisor on a start strobe and iterates one quotient bit per clock. It returns an N-bit quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit and shares its operand naming (A, B) and its clock/reset scheme.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// DIV_SIGNED_EN selects the two's-complement build, which adds a sign-fix state.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  // Edges from the accepting edge to done for a nonzero divisor.
  function automatic int unsigned div_latency(input int unsigned n);
`ifdef DIV_SIGNED_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract div, keep or restore.
module div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] div,
  output logic [N:0]   rem_next,
  output logic [N-1:0] quo_next
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;
  logic         fits;

  always_comb begin
    shifted  = {rem, quo[N-1]};
    diff     = shifted - {2'b00, div};
    // No borrow out of the top bit means the divisor fit into the shifted remainder.
    fits     = ~diff[N+1];
    rem_next = fits ? diff[N:0] : shifted[N:0];
    quo_next = {quo[N-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock with a one-cycle done pulse.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign-fix cycle).
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] Q,
  output logic [N-1:0] R
);

  localparam int unsigned CntW = $clog2(N + 1);

  div_state_e    state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  mag_a, mag_b;
  logic [N:0]    step_rem;
  logic [N-1:0]  step_quo;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign mag_a = A[N-1] ? (~A + 1'b1) : A;
  assign mag_b = B[N-1] ? (~B + 1'b1) : B;
`else
  assign mag_a = A;
  assign mag_b = B;
`endif

  div_step #(
    .N(N)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .div      (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = mag_a;
            div_d   = mag_b;
            cnt_d   = CntW'(N);
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_d = A[N-1] ^ B[N-1];
            neg_rem_d = A[N-1];
`endif
            state_d = StIter;
          end
        end
      end

      StIter: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          q_d = step_quo;
          r_d = step_rem[N-1:0];
`ifdef DIV_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end

      StFix: begin
`ifdef DIV_SIGNED_EN
        // Magnitude -MIN stays MIN after negation, giving the expected overflow quotient.
        if (neg_quo_q) q_d = ~q_q + 1'b1;
        if (neg_rem_q) r_d = ~r_q + 1'b1;
        state_d = StDone;
`else
        state_d = StIdle;
`endif
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign Q           = q_q;
  assign R           = r_q;

endmodule
